cfg_inst_dispatcher: RTL
========================

// Module: cfg_inst_dispatcher
// PURPOSE
//  Upstream feeder of the accelerator config port. Fetches packed config instructions from a
//  1-cycle-latency instruction SRAM and splits each word into data/wicp/tmpc/post fields.
//  Presents each instruction on a cfg_valid/cfg_busy handshake; sustains 1 instruction/cycle.
// PARAMETERS
//  DATA_CWIDTH  32  width of cfg_data_data field
//  WICP_CWIDTH  32  width of cfg_wicp_data field
//  TMPC_CWIDTH  32  width of cfg_tmpc_data field
//  POST_CWIDTH  32  width of cfg_post_data field
//  IAWIDTH      10  instruction memory address width
//  (derived) IWIDTH = POST_CWIDTH+TMPC_CWIDTH+WICP_CWIDTH+DATA_CWIDTH
// PORTS
//  clk             in   1        clock, all logic on rising edge
//  rst_n           in   1        asynchronous active-low reset
//  start           in   1        one-cycle launch request, sampled only in IDLE
//  start_addr      in   IAWIDTH  first instruction address
//  inst_num        in   IAWIDTH  number of instructions to issue (0 allowed)
//  idle            out  1        high in IDLE
//  done            out  1        one-cycle pulse after the last instruction is accepted
//  inst_mem_ren    out  1        SRAM read enable
//  inst_mem_addr   out  IAWIDTH  SRAM read address
//  inst_mem_rdata  in   IWIDTH   SRAM data, valid the cycle after ren
//  cfg_valid       out  1        instruction presented
//  cfg_busy        in   1        consumer busy; transfer = cfg_valid & ~cfg_busy at posedge
//  cfg_data_data   out  DATA_CWIDTH  word[DATA_CWIDTH-1:0]
//  cfg_wicp_data   out  WICP_CWIDTH  next field up
//  cfg_tmpc_data   out  TMPC_CWIDTH  next field up
//  cfg_post_data   out  POST_CWIDTH  word[IWIDTH-1 -: POST_CWIDTH]
// BEHAVIOUR
//  Reset: state=IDLE, idle=1, done=0, inst_mem_ren=0, inst_mem_addr=0, cfg_valid=0,
//   all cfg_*_data=0, FIFO empty, counters 0. Reset mid-run aborts; no done pulse.
//  FSM:
//   IDLE --start & inst_num!=0--> FETCH
//   IDLE --start & inst_num==0--> DONE
//   FETCH --last read issued--> DRAIN
//   DRAIN --last transfer--> DONE
//   DONE --1 cycle, done=1--> IDLE
//  start outside IDLE is ignored. start_addr and inst_num are latched at the start edge.
//  Reads: in FETCH assert ren when issued_cnt<inst_num and (fifo_count+inflight)<2.
//   inflight is the read issued last cycle. Address increments per read and wraps modulo
//   2^IAWIDTH.
//  rdata is written to a 2-entry FIFO on the edge after the ren cycle; the FIFO never overflows
//   by construction (assertion).
//  Output: cfg_valid = FIFO non-empty; cfg_* = FIFO head, driven from registers.
//   Fields must hold stable while cfg_valid & cfg_busy. Pop on cfg_valid & ~cfg_busy.
//  Latency: start in cycle 0 -> ren in cycle 1 -> cfg_valid=1 in cycle 3 (cfg_busy=0).
//  Throughput: with cfg_busy=0, one transfer per cycle back-to-back.
//  Simultaneous push+pop when full is legal; count is unchanged.
//  done asserts the cycle after the inst_num-th transfer, or 1 cycle after start when
//   inst_num==0 (no ren, no cfg_valid).
//  cfg_busy stuck high: reads stop once 2 entries are held or in flight, no data loss.
// STRUCTURE
//  Package cfg_dispatch_pkg: state enum {IDLE,FETCH,DRAIN,DONE}; field width constants;
//   a typedef for the packed instruction struct {post,tmpc,wicp,data}.
//  One sub-module: cfg_skid_fifo (2-entry, IWIDTH wide, push/pop/count/full/empty).
//   Top holds the FSM, address and issue/accept counters, and field unpacking.
// TESTING
//  1. start_addr=0, inst_num=4, busy=0, mem[i]=i-tagged fields -> 4 consecutive transfers
//     cycles 3..6, in order; done=1 in cycle 7.
//  2. inst_num=0 -> no ren, no cfg_valid; done pulse 1 cycle after start; idle returns.
//  3. inst_num=5, busy high cycles 3..12 -> cfg_valid held, fields stable; <=2 reads
//     outstanding; all 5 delivered in order after release.
//  4. start_addr=2^IAWIDTH-2, inst_num=4 -> addresses 1022,1023,0,1 (IAWIDTH=10).
//  5. Random busy toggling, inst_num=64 -> scoreboard match, no FIFO overflow assertion hit.
//  6. rst_n low mid-DRAIN, then new start -> outputs at reset values, fresh sequence
//     delivered correctly, no stale entry.

Source files
------------

// File: rtl/cfg_dispatch_pkg.sv
// Shared definitions for the config instruction dispatcher.
//  - default field widths of a packed config instruction
//  - FSM state encodings (plain localparams for legacy tool compatibility)
//  - packed instruction struct, MSB to LSB: post, tmpc, wicp, data
package cfg_dispatch_pkg;

  localparam int unsigned DataCw = 32;
  localparam int unsigned WicpCw = 32;
  localparam int unsigned TmpcCw = 32;
  localparam int unsigned PostCw = 32;
  localparam int unsigned InstW  = PostCw + TmpcCw + WicpCw + DataCw;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StFetch = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

  typedef struct packed {
    logic [PostCw-1:0] post;
    logic [TmpcCw-1:0] tmpc;
    logic [WicpCw-1:0] wicp;
    logic [DataCw-1:0] data;
  } cfg_inst_t;

endpackage

// File: rtl/cfg_skid_fifo.sv
// Two-entry FIFO holding fetched instructions in front of the config port.
// Ports:
//  clk_i, rst_ni   clock, asynchronous active-low reset
//  push_i/wdata_i  write request and data
//  pop_i           read request (ignored when empty)
//  rdata_o         head entry, straight from storage registers
//  count_o         occupancy 0..2
//  full_o/empty_o  occupancy flags
// Push and pop in the same cycle while full is legal: the head slot is freed and refilled.
module cfg_skid_fifo #(
  parameter int unsigned Width = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [1:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The read issue logic reserves a slot for every outstanding read, so this never fires.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/cfg_inst_dispatcher.sv
// Config instruction dispatcher: fetches inst_num packed words from a 1-cycle-latency
// instruction SRAM starting at start_addr and presents each one on the config port.
// Ports:
//  clk, rst_n                    clock, asynchronous active-low reset
//  start, start_addr, inst_num   launch request (sampled in IDLE only) and its arguments
//  idle, done                    status: idle level, one-cycle completion pulse
//  inst_mem_ren/addr/rdata       SRAM read port, rdata valid the cycle after ren
//  cfg_valid, cfg_busy           config handshake, transfer = cfg_valid & ~cfg_busy
//  cfg_{data,wicp,tmpc,post}_data  fields of the head instruction, LSB field first
module cfg_inst_dispatcher
  import cfg_dispatch_pkg::*;
#(
  parameter int unsigned DATA_CWIDTH = DataCw,
  parameter int unsigned WICP_CWIDTH = WicpCw,
  parameter int unsigned TMPC_CWIDTH = TmpcCw,
  parameter int unsigned POST_CWIDTH = PostCw,
  parameter int unsigned IAWIDTH     = 10,
  localparam int unsigned IWIDTH     = POST_CWIDTH + TMPC_CWIDTH + WICP_CWIDTH + DATA_CWIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [IAWIDTH-1:0]     start_addr,
  input  logic [IAWIDTH-1:0]     inst_num,
  output logic                   idle,
  output logic                   done,
  output logic                   inst_mem_ren,
  output logic [IAWIDTH-1:0]     inst_mem_addr,
  input  logic [IWIDTH-1:0]      inst_mem_rdata,
  output logic                   cfg_valid,
  input  logic                   cfg_busy,
  output logic [DATA_CWIDTH-1:0] cfg_data_data,
  output logic [WICP_CWIDTH-1:0] cfg_wicp_data,
  output logic [TMPC_CWIDTH-1:0] cfg_tmpc_data,
  output logic [POST_CWIDTH-1:0] cfg_post_data
);

  localparam logic [IAWIDTH-1:0] AddrOne = IAWIDTH'(1);

  state_t             state_q, state_d;
  logic [IAWIDTH-1:0] addr_q, addr_d;
  logic [IAWIDTH-1:0] num_q, num_d;
  logic [IAWIDTH-1:0] issued_q, issued_d;
  logic [IAWIDTH-1:0] accepted_q, accepted_d;
  logic               inflight_q;

  logic [IWIDTH-1:0]  fifo_head;
  logic [1:0]         fifo_count;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [2:0]         occ_after;

  assign cfg_valid = ~fifo_empty;
  assign fifo_pop  = cfg_valid & ~cfg_busy;
  // Slots held after this cycle's pop; counting the pop keeps 1 transfer/cycle sustainable.
  assign occ_after = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};

  assign idle          = (state_q == StIdle);
  assign done          = (state_q == StDone);
  assign inst_mem_addr = addr_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    num_d        = num_q;
    issued_d     = issued_q;
    accepted_d   = accepted_q;
    inst_mem_ren = 1'b0;
    if (fifo_pop) begin
      accepted_d = accepted_q + AddrOne;
    end
    case (state_q)
      StIdle: begin
        if (start) begin
          num_d      = inst_num;
          addr_d     = start_addr;
          issued_d   = '0;
          accepted_d = '0;
          state_d    = (inst_num != '0) ? StFetch : StDone;
        end
      end
      StFetch: begin
        if ((issued_q < num_q) && (occ_after < 3'd2)) begin
          inst_mem_ren = 1'b1;
          addr_d       = addr_q + AddrOne;
          issued_d     = issued_q + AddrOne;
          if (issued_q == num_q - AddrOne) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (fifo_pop && (accepted_q == num_q - AddrOne)) begin
          state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      inflight_q <= inst_mem_ren;
    end
  end

  // Read data lands the cycle after ren, so the registered ren is the push strobe.
  cfg_skid_fifo #(
    .Width (IWIDTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (inflight_q),
    .pop_i   (fifo_pop),
    .wdata_i (inst_mem_rdata),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  a_no_issue_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(inst_mem_ren && fifo_full && !fifo_pop));

  assign cfg_data_data = fifo_head[DATA_CWIDTH-1:0];
  assign cfg_wicp_data = fifo_head[DATA_CWIDTH +: WICP_CWIDTH];
  assign cfg_tmpc_data = fifo_head[DATA_CWIDTH + WICP_CWIDTH +: TMPC_CWIDTH];
  assign cfg_post_data = fifo_head[IWIDTH-1 -: POST_CWIDTH];

endmodule
